mealy_seq_detector: RTL and testbench

//  Parametrised serial bit-pattern detector: N_PAT independent patterns of PAT_LEN bits each, checked against one

---
 rtl/mealy_seq_pkg.sv | 17 +
 rtl/mealy_seq_lane.sv | 55 +++++
 rtl/mealy_seq_detector.sv | 57 +++++
 tb/tb_mealy_seq_detector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Defaults give 101 on lane 0 and 010 on lane 1.
package mealy_seq_pkg;

   localparam int N_PAT_D   = 2;
   localparam int PAT_LEN_D = 3;
   localparam int CNT_W_D   = 8;

   localparam logic [N_PAT_D*PAT_LEN_D-1:0] PATTERNS_D =
      {3'b010, 3'b101};

   // Low bit of lane k inside a flat vector of w-bit fields.
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/mealy_seq_lane.sv
// One detector lane: fill tracking, pattern compare and a
// saturating match counter, fed by the shared history window.
module mealy_seq_lane #(
   parameter int                 PAT_LEN = 3,
   parameter int                 CNT_W   = 8,
   parameter logic [PAT_LEN-1:0] PATTERN = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [PAT_LEN-1:0] window,
   input  logic               accept,
   input  logic               clear,
   input  logic               overlap,
   output logic               hit,
   output logic [CNT_W-1:0]   cnt
);

   localparam int FW = $clog2(PAT_LEN);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

   logic [FW-1:0]    fill;
   logic [FW-1:0]    fill_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign hit = accept & ~reset & (fill == FULL) &
                (window == PATTERN);

   always_comb begin
      fill_nxt = fill;
      cnt_nxt  = cnt;
      if (clear) begin
         fill_nxt = '0;
         cnt_nxt  = '0;
      end else if (accept) begin
         // Non-overlap mode restarts this lane's window only.
         if (hit & ~overlap)
            fill_nxt = '0;
         else if (fill != FULL)
            fill_nxt = fill + 1'b1;
         if (hit & ~&cnt)
            cnt_nxt = cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fill <= '0;
         cnt  <= '0;
      end else begin
         fill <= fill_nxt;
         cnt  <= cnt_nxt;
      end
   end

endmodule

// File: rtl/mealy_seq_detector.sv
// Multi-pattern Mealy serial detector: shared bit history,
// one lane per pattern, zero-latency match flags.
module mealy_seq_detector
   import mealy_seq_pkg::*;
#(
   parameter int N_PAT   = N_PAT_D,
   parameter int PAT_LEN = PAT_LEN_D,
   parameter logic [N_PAT*PAT_LEN-1:0] PATTERNS = PATTERNS_D,
   parameter int CNT_W   = CNT_W_D
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i,
   input  logic                   i_valid,
   input  logic                   overlap,
   input  logic                   clear,
   output logic [N_PAT-1:0]       o,
   output logic [N_PAT*CNT_W-1:0] match_cnt
);

   localparam int HW = PAT_LEN - 1;

   logic [HW-1:0]      hist;
   logic [PAT_LEN-1:0] window;
   logic               accept;

   assign accept = i_valid & ~clear;
   assign window = {hist, i};

   // Truncation drops the oldest bit, covering PAT_LEN == 2 too.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         hist <= '0;
      else if (clear)
         hist <= '0;
      else if (i_valid)
         hist <= HW'(window);
   end

   for (genvar k = 0; k < N_PAT; k++) begin : g_lane
      mealy_seq_lane #(
         .PAT_LEN (PAT_LEN),
         .CNT_W   (CNT_W),
         .PATTERN (PATTERNS[lane_lsb(k, PAT_LEN) +: PAT_LEN])
      ) u_lane (
         .clock   (clock),
         .reset   (reset),
         .window  (window),
         .accept  (accept),
         .clear   (clear),
         .overlap (overlap),
         .hit     (o[k]),
         .cnt     (match_cnt[lane_lsb(k, CNT_W) +: CNT_W])
      );
   end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector: three configurations,
// directed bit streams with hand-computed flags and counts.
module tb_mealy_seq_detector;

   typedef struct {
      int          d;
      string       nm;
      logic [2:0]  eo;
      logic [23:0] ec;
   } exp_t;

   logic        clock = 1'b0;
   logic [2:0]  rst = 3'b111;
   logic [2:0]  di = '0;
   logic [2:0]  dv = '0;
   logic [2:0]  dov = '0;
   logic [2:0]  dcl = '0;

   logic [1:0]  o0;
   logic [15:0] c0;
   logic [1:0]  o1;
   logic [3:0]  c1;
   logic [2:0]  o2;
   logic [23:0] c2;

   exp_t q[$];
   exp_t e;
   logic [2:0]  ao;
   logic [23:0] ac;
   int compared = 0;
   int mismatched = 0;

   int o5[13] = '{0, 0, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
   int c5[13] = '{0, 0, 0, 1, 5, 6, 10, 11, 15, 15, 15, 15, 15};

   always #5 clock = ~clock;

   mealy_seq_detector dut0 (
      .clock     (clock),
      .reset     (rst[0]),
      .i         (di[0]),
      .i_valid   (dv[0]),
      .overlap   (dov[0]),
      .clear     (dcl[0]),
      .o         (o0),
      .match_cnt (c0)
   );

   mealy_seq_detector #(.CNT_W(2)) dut1 (
      .clock     (clock),
      .reset     (rst[1]),
      .i         (di[1]),
      .i_valid   (dv[1]),
      .overlap   (dov[1]),
      .clear     (dcl[1]),
      .o         (o1),
      .match_cnt (c1)
   );

   mealy_seq_detector #(
      .N_PAT    (3),
      .PAT_LEN  (4),
      .PATTERNS ({4'b1111, 4'b1111, 4'b0110}),
      .CNT_W    (8)
   ) dut2 (
      .clock     (clock),
      .reset     (rst[2]),
      .i         (di[2]),
      .i_valid   (dv[2]),
      .overlap   (dov[2]),
      .clear     (dcl[2]),
      .o         (o2),
      .match_cnt (c2)
   );

   // Monitor: one expected entry per driven cycle, checked mid-cycle.
   always @(negedge clock) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         case (e.d)
            0:       begin ao = {1'b0, o0}; ac = {8'h0, c0}; end
            1:       begin ao = {1'b0, o1}; ac = {20'h0, c1}; end
            default: begin ao = o2; ac = c2; end
         endcase
         compared++;
         if (ao !== e.eo || ac !== e.ec) begin
            mismatched++;
            $display("FAIL %s dut%0d: o=%b cnt=%h, want o=%b cnt=%h",
                     e.nm, e.d, ao, ac, e.eo, e.ec);
         end
      end
   end

   function automatic logic [23:0] p0(input int a, input int b);
      logic [7:0] la;
      logic [7:0] lb;
      la = a[7:0];
      lb = b[7:0];
      return {8'h0, lb, la};
   endfunction

   task automatic step(input int d, input logic b, input logic v,
                       input logic ov, input logic cl, input string nm,
                       input logic [2:0] eo, input logic [23:0] ec);
      exp_t t;
      di[d]  = b;
      dv[d]  = v;
      dov[d] = ov;
      dcl[d] = cl;
      t.d = d;
      t.nm = nm;
      t.eo = eo;
      t.ec = ec;
      q.push_back(t);
      @(posedge clock);
      #1;
      dv[d]  = 1'b0;
      dcl[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit expired, queue=%0d", q.size());
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      step(0, 1, 1, 1, 0, "in_reset", 3'b000, p0(0, 0));
      rst = 3'b000;

      // overlapping: 1,0,1,0,1
      step(0, 1, 1, 1, 0, "ov_b1", 3'b000, p0(0, 0));
      step(0, 0, 1, 1, 0, "ov_b2", 3'b000, p0(0, 0));
      step(0, 1, 1, 1, 0, "ov_b3", 3'b001, p0(0, 0));
      step(0, 0, 1, 1, 0, "ov_b4", 3'b010, p0(1, 0));
      step(0, 1, 1, 1, 0, "ov_b5", 3'b001, p0(1, 1));
      step(0, 0, 0, 1, 0, "ov_cnt", 3'b000, p0(2, 1));
      step(0, 0, 1, 1, 1, "clr_sup", 3'b000, p0(2, 1));

      // non-overlapping: 1,0,1,0,1,0,1
      step(0, 1, 1, 0, 0, "no_b1", 3'b000, p0(0, 0));
      step(0, 0, 1, 0, 0, "no_b2", 3'b000, p0(0, 0));
      step(0, 1, 1, 0, 0, "no_b3", 3'b001, p0(0, 0));
      step(0, 0, 1, 0, 0, "no_b4", 3'b010, p0(1, 0));
      step(0, 1, 1, 0, 0, "no_b5", 3'b000, p0(1, 1));
      step(0, 0, 1, 0, 0, "no_b6", 3'b000, p0(1, 1));
      step(0, 1, 1, 0, 0, "no_b7", 3'b001, p0(1, 1));
      step(0, 0, 0, 0, 0, "no_cnt", 3'b000, p0(2, 1));
      step(0, 0, 1, 0, 1, "clr2", 3'b000, p0(2, 1));

      // stall between 1,0 and the final 1
      step(0, 1, 1, 1, 0, "st_b1", 3'b000, p0(0, 0));
      step(0, 0, 1, 1, 0, "st_b2", 3'b000, p0(0, 0));
      for (int s = 0; s < 3; s++)
         step(0, 1, 0, 1, 0, "st_hold", 3'b000, p0(0, 0));
      step(0, 1, 1, 1, 0, "st_b3", 3'b001, p0(0, 0));
      step(0, 0, 0, 1, 0, "st_cnt", 3'b000, p0(1, 0));
      step(0, 0, 1, 1, 1, "clr3", 3'b000, p0(1, 0));

      // clear mid-pattern restarts fill
      step(0, 0, 1, 1, 0, "cl_b1", 3'b000, p0(0, 0));
      step(0, 1, 1, 1, 0, "cl_b2", 3'b000, p0(0, 0));
      step(0, 0, 1, 1, 1, "cl_clr", 3'b000, p0(0, 0));
      step(0, 0, 1, 1, 0, "cl_b3", 3'b000, p0(0, 0));
      step(0, 1, 1, 1, 0, "cl_b4", 3'b000, p0(0, 0));
      step(0, 0, 1, 1, 0, "cl_b5", 3'b010, p0(0, 0));
      step(0, 0, 0, 1, 0, "cl_cnt", 3'b000, p0(0, 1));

      // 2-bit counters saturate at 3
      for (int n = 0; n < 13; n++)
         step(1, logic'(n % 2 == 0), 1, 1, 0, "sat",
              3'(o5[n]), 24'(c5[n]));
      step(1, 0, 0, 1, 0, "sat_cnt", 3'b000, 24'hF);

      // async reset between edges while a match is presented
      di[1] = 1'b0;
      dv[1] = 1'b1;
      q.push_back('{1, "async_rst", 3'b000, 24'h0});
      #2 rst[1] = 1'b1;
      @(negedge clock);
      #1;
      dv[1]  = 1'b0;
      rst[1] = 1'b0;
      @(posedge clock);
      #1;
      step(1, 1, 1, 1, 0, "ar_b1", 3'b000, 24'h0);
      step(1, 0, 1, 1, 0, "ar_b2", 3'b000, 24'h0);
      step(1, 1, 1, 1, 0, "ar_b3", 3'b001, 24'h0);
      step(1, 0, 0, 1, 0, "ar_cnt", 3'b000, 24'h1);

      // 3 lanes x 4 bits, identical patterns on lanes 1 and 2
      step(2, 1, 1, 1, 0, "w_b1", 3'b000, 24'h0);
      step(2, 1, 1, 1, 0, "w_b2", 3'b000, 24'h0);
      step(2, 1, 1, 1, 0, "w_b3", 3'b000, 24'h0);
      step(2, 1, 1, 1, 0, "w_b4", 3'b110, 24'h0);
      step(2, 1, 1, 1, 0, "w_b5", 3'b110, 24'h010100);
      step(2, 0, 0, 1, 0, "w_cnt", 3'b000, 24'h020200);

      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
